// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core load/store and data-memory signals of the store buffer
interface store_buffer_if #(
  parameter int ADDR_MEM_WIDTH = 32
);
  logic [ADDR_MEM_WIDTH-1:0] i_addr;
  logic [31:0]               i_data;
  logic                      i_we;
  logic                      i_re;
  logic [31:0]               o_data;
  logic                      o_valid;
  logic                      o_full;
  logic                      o_busy;
  logic [ADDR_MEM_WIDTH-1:0] o_mem_addr;
  logic [31:0]               o_mem_data;
  logic                      o_mem_we;
  logic                      o_mem_re;
  logic [31:0]               i_mem_data;
  logic                      i_mem_ready;

  modport slave (
    input  i_addr, i_data, i_we, i_re, i_mem_data, i_mem_ready,
    output o_data, o_valid, o_full, o_busy, o_mem_addr, o_mem_data, o_mem_we, o_mem_re
  );

  modport master (
    output i_addr, i_data, i_we, i_re, i_mem_data, i_mem_ready,
    input  o_data, o_valid, o_full, o_busy, o_mem_addr, o_mem_data, o_mem_we, o_mem_re
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO draining to data memory with youngest-match load forwarding
module store_buffer #(
  parameter int ADDR_MEM_WIDTH = 32,
  parameter int WIDTH_PTR      = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  store_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** WIDTH_PTR;
  localparam logic [WIDTH_PTR:0]   DEPTH_CNT = (WIDTH_PTR + 1)'(DEPTH);
  localparam logic [WIDTH_PTR:0]   CNT_ONE   = 1;
  localparam logic [WIDTH_PTR-1:0] PTR_ONE   = 1;

  typedef enum logic {IDLE, RD_MEM} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH_PTR-1:0]      head_q, head_d, tail_q, tail_d;
  logic [WIDTH_PTR:0]        count_q, count_d;
  logic [ADDR_MEM_WIDTH-1:0] ent_addr_q [DEPTH];
  logic [ADDR_MEM_WIDTH-1:0] ent_addr_d [DEPTH];
  logic [31:0]               ent_data_q [DEPTH];
  logic [31:0]               ent_data_d [DEPTH];
  logic [ADDR_MEM_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]               o_data_q, o_data_d;
  logic                      o_valid_q, o_valid_d;

  logic                      full, push, drain, pop, hit;
  logic [31:0]               fwd_data;
  logic [WIDTH_PTR-1:0]      idx;

  assign full  = (count_q == DEPTH_CNT);
  assign push  = bus.i_we && !full;
  assign drain = (state_q == IDLE) && (count_q != '0);
  assign pop   = drain && bus.i_mem_ready;

  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    // Walk oldest to youngest so the last match seen is the youngest one.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + WIDTH_PTR'(i);
      if (((WIDTH_PTR + 1)'(i) < count_q) &&
          (ent_addr_q[idx][ADDR_MEM_WIDTH-1:2] == bus.i_addr[ADDR_MEM_WIDTH-1:2])) begin
        hit      = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
    if (push) begin
      hit      = 1'b1;
      fwd_data = bus.i_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    rd_addr_d  = rd_addr_q;
    o_data_d   = o_data_q;
    o_valid_d  = 1'b0;

    if (push) begin
      ent_addr_d[tail_q] = bus.i_addr;
      ent_data_d[tail_q] = bus.i_data;
      tail_d             = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.i_re) begin
          if (hit) begin
            o_data_d  = fwd_data;
            o_valid_d = 1'b1;
          end else begin
            rd_addr_d = bus.i_addr;
            state_d   = RD_MEM;
          end
        end
      end
      RD_MEM: begin
        if (bus.i_mem_ready) begin
          o_data_d  = bus.i_mem_data;
          o_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_addr_q <= '{default: '0};
      ent_data_q <= '{default: '0};
      rd_addr_q  <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      rd_addr_q  <= rd_addr_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_full     = full;
  assign bus.o_busy     = (state_q == RD_MEM);
  assign bus.o_mem_we   = drain;
  assign bus.o_mem_re   = (state_q == RD_MEM);
  assign bus.o_mem_addr = (state_q == RD_MEM) ? rd_addr_q :
                          drain               ? ent_addr_q[head_q] : '0;
  assign bus.o_mem_data = drain ? ent_data_q[head_q] : '0;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  store_buffer_if #(.ADDR_MEM_WIDTH(32)) bus ();

  store_buffer #(.ADDR_MEM_WIDTH(32), .WIDTH_PTR(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},     bus.o_data,     32'h0);
    chk({tag, "_valid"},    32'(bus.o_valid),  32'h0);
    chk({tag, "_full"},     32'(bus.o_full),   32'h0);
    chk({tag, "_busy"},     32'(bus.o_busy),   32'h0);
    chk({tag, "_mem_we"},   32'(bus.o_mem_we), 32'h0);
    chk({tag, "_mem_re"},   32'(bus.o_mem_re), 32'h0);
    chk({tag, "_mem_addr"}, bus.o_mem_addr, 32'h0);
    chk({tag, "_mem_data"}, bus.o_mem_data, 32'h0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.i_addr      = '0;
    bus.i_data      = '0;
    bus.i_we        = 1'b0;
    bus.i_re        = 1'b0;
    bus.i_mem_data  = '0;
    bus.i_mem_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single store then drain
    bus.i_we = 1'b1; bus.i_addr = 32'h100; bus.i_data = 32'h11;
    tick();
    bus.i_we = 1'b0;
    #1;
    chk("st1_mem_we",   32'(bus.o_mem_we), 32'h1);
    chk("st1_mem_addr", bus.o_mem_addr, 32'h100);
    chk("st1_mem_data", bus.o_mem_data, 32'h11);
    chk("st1_mem_re",   32'(bus.o_mem_re), 32'h0);
    bus.i_mem_ready = 1'b1;
    tick();
    #1;
    chk("st1_drained_we",   32'(bus.o_mem_we), 32'h0);
    chk("st1_drained_addr", bus.o_mem_addr, 32'h0);

    // Fill to full, drop fifth store, drain in order
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_we = 1'b1; bus.i_addr = 32'(i * 4); bus.i_data = 32'h20 + 32'(i);
      tick();
    end
    bus.i_we = 1'b0;
    #1;
    chk("fill_full", 32'(bus.o_full), 32'h1);
    bus.i_we = 1'b1; bus.i_addr = 32'h10; bus.i_data = 32'h99;
    tick();
    bus.i_we = 1'b0;
    #1;
    chk("drop_full", 32'(bus.o_full), 32'h1);
    chk("drop_head", bus.o_mem_addr, 32'h0);
    bus.i_mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d_we", k),   32'(bus.o_mem_we), 32'h1);
      chk($sformatf("drain%0d_addr", k), bus.o_mem_addr, 32'(k * 4));
      chk($sformatf("drain%0d_data", k), bus.o_mem_data, 32'h20 + 32'(k));
      tick();
      if (k == 0) chk("full_drop_after_pop", 32'(bus.o_full), 32'h0);
    end
    #1;
    chk("fifth_dropped_we", 32'(bus.o_mem_we), 32'h0);

    // Youngest of two matching entries forwarded, sub-word address
    bus.i_mem_ready = 1'b0;
    bus.i_we = 1'b1; bus.i_addr = 32'h20; bus.i_data = 32'hAA;
    tick();
    bus.i_data = 32'hBB;
    tick();
    bus.i_we = 1'b0; bus.i_re = 1'b1; bus.i_addr = 32'h22;
    tick();
    bus.i_re = 1'b0;
    #1;
    chk("fwd_valid",  32'(bus.o_valid),  32'h1);
    chk("fwd_data",   bus.o_data,        32'hBB);
    chk("fwd_mem_re", 32'(bus.o_mem_re), 32'h0);
    chk("fwd_busy",   32'(bus.o_busy),   32'h0);
    tick();
    chk("fwd_pulse", 32'(bus.o_valid), 32'h0);
    bus.i_mem_ready = 1'b1;
    tick();
    tick();
    bus.i_mem_ready = 1'b0;
    #1;
    chk("fwd_drained", 32'(bus.o_mem_we), 32'h0);

    // Same-cycle store and load
    bus.i_we = 1'b1; bus.i_re = 1'b1; bus.i_addr = 32'h40; bus.i_data = 32'h5;
    tick();
    bus.i_we = 1'b0; bus.i_re = 1'b0;
    #1;
    chk("same_valid",    32'(bus.o_valid), 32'h1);
    chk("same_data",     bus.o_data,       32'h5);
    chk("same_mem_addr", bus.o_mem_addr,   32'h40);
    bus.i_mem_ready = 1'b1;
    tick();
    bus.i_mem_ready = 1'b0;

    // Load miss with memory wait and a store accepted meanwhile
    bus.i_re = 1'b1; bus.i_addr = 32'h80;
    tick();
    bus.i_re = 1'b0;
    bus.i_we = 1'b1; bus.i_addr = 32'h90; bus.i_data = 32'h77;
    #1;
    chk("miss_busy",     32'(bus.o_busy),   32'h1);
    chk("miss_mem_re",   32'(bus.o_mem_re), 32'h1);
    chk("miss_mem_we",   32'(bus.o_mem_we), 32'h0);
    chk("miss_mem_addr", bus.o_mem_addr,    32'h80);
    chk("miss_valid",    32'(bus.o_valid),  32'h0);
    tick();
    bus.i_we = 1'b0;
    bus.i_re = 1'b1; bus.i_addr = 32'h90;
    #1;
    chk("miss_suspend_we", 32'(bus.o_mem_we), 32'h0);
    chk("miss_hold_addr",  bus.o_mem_addr,    32'h80);
    tick();
    bus.i_re = 1'b0;
    #1;
    chk("miss_re_ignored", 32'(bus.o_valid), 32'h0);
    chk("miss_busy2",      32'(bus.o_busy),  32'h1);
    tick();
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 32'hDEAD;
    #1;
    chk("miss_busy3", 32'(bus.o_busy), 32'h1);
    tick();
    bus.i_mem_ready = 1'b0;
    #1;
    chk("miss_valid_after", 32'(bus.o_valid),  32'h1);
    chk("miss_data",        bus.o_data,        32'hDEAD);
    chk("miss_idle",        32'(bus.o_busy),   32'h0);
    chk("post_miss_we",     32'(bus.o_mem_we), 32'h1);
    chk("post_miss_addr",   bus.o_mem_addr,    32'h90);
    chk("post_miss_data",   bus.o_mem_data,    32'h77);
    tick();
    chk("miss_pulse", 32'(bus.o_valid), 32'h0);
    chk("miss_hold",  bus.o_data,       32'hDEAD);

    // Reset mid-miss with two entries buffered
    bus.i_we = 1'b1; bus.i_addr = 32'h94; bus.i_data = 32'h78;
    tick();
    bus.i_we = 1'b0; bus.i_re = 1'b1; bus.i_addr = 32'hA0;
    tick();
    bus.i_re = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(bus.o_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d_valid", k),  32'(bus.o_valid),  32'h0);
      chk($sformatf("post_rst%0d_mem_we", k), 32'(bus.o_mem_we), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
